// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: 4-to-2 one-hot encoder with a one-deep valid/ready output
// register and a saturating count of good words.
// Define ONEHOT_ENC_PRIORITY_EN to encode multi-hot words as their highest set
// index; without it multi-hot words are flagged as errors.
module onehot_encoder_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_onehot,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_err,
    output logic [CNT_W-1:0] good_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state;
    logic       accept;
    logic [1:0] enc_code;
    logic       enc_err;

    // A full slot can still take a new word in the same cycle it is drained
    assign in_ready  = (state == EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == FULL);

`ifdef ONEHOT_ENC_PRIORITY_EN
    // Highest set bit wins; only the all-zero word is illegal
    always_comb begin
        enc_err  = (in_onehot == 4'b0000);
        enc_code = in_onehot[3] ? 2'd3 : in_onehot[2] ? 2'd2 : in_onehot[1] ? 2'd1 : 2'd0;
    end
`else
    // Exactly one bit must be set; anything else encodes as 00 with an error
    always_comb begin
        enc_err  = (in_onehot == 4'b0000) || ((in_onehot & (in_onehot - 4'd1)) != 4'b0000);
        enc_code = enc_err ? 2'd0 : {in_onehot[3] | in_onehot[2], in_onehot[3] | in_onehot[1]};
    end
`endif

    // Output slot FSM with registered result and saturating good-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_code <= 2'd0;
            out_err  <= 1'b0;
            good_cnt <= '0;
        end else if (accept) begin
            state    <= FULL;
            out_code <= enc_code;
            out_err  <= enc_err;
            if (!enc_err && !(&good_cnt))
                good_cnt <= good_cnt + CNT_W'(1);
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_seq.sv
// tb_onehot_encoder_seq: directed self-checking bench for onehot_encoder_seq
module tb_onehot_encoder_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_onehot = 4'b0000;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_err;
    logic [1:0] out_code;
    logic [7:0] good_cnt;
    logic       in_ready2, out_valid2, out_err2;
    logic [1:0] out_code2;
    logic [1:0] good_cnt2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_encoder_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_onehot(in_onehot),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_err(out_err), .good_cnt(good_cnt)
    );

    onehot_encoder_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_onehot(in_onehot),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_code(out_code2), .out_err(out_err2), .good_cnt(good_cnt2)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_onehot = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_code !== 2'd0) begin errors++; $display("FAIL reset_out_code: got %0d exp 0", out_code); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b exp 0", out_err); end
        checks++; if (good_cnt !== 8'd0) begin errors++; $display("FAIL reset_good_cnt: got %0d exp 0", good_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_onehot = 4'b0001 << i;
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_code !== 2'(i)) begin errors++; $display("FAIL b2b_code[%0d]: got %0d exp %0d", i, out_code, i); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b exp 0", i, out_err); end
            checks++; if (good_cnt !== 8'(i + 1)) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d exp %0d", i, good_cnt, i + 1); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
        checks++; if (good_cnt !== 8'd4) begin errors++; $display("FAIL b2b_final_cnt: got %0d exp 4", good_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1;
        in_onehot = 4'b1000;
        out_ready = 1'b0;
        tick();
        in_onehot = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_code !== 2'd3) begin errors++; $display("FAIL bp_code[%0d]: got %0d exp 3", i, out_code); end
            checks++; if (good_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt[%0d]: got %0d exp 1", i, good_cnt); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_code !== 2'd0) begin errors++; $display("FAIL bp_next_code: got %0d exp 0", out_code); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b exp 1", out_valid); end
        checks++; if (good_cnt !== 8'd2) begin errors++; $display("FAIL bp_next_cnt: got %0d exp 2", good_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [1:0] exp_code;
        logic       exp_err;
        logic [7:0] exp_cnt;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_onehot = 4'b0000;
        tick();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL zero_err: got %b exp 1", out_err); end
        checks++; if (out_code !== 2'd0) begin errors++; $display("FAIL zero_code: got %0d exp 0", out_code); end
        checks++; if (good_cnt !== 8'd0) begin errors++; $display("FAIL zero_cnt: got %0d exp 0", good_cnt); end
        in_onehot = 4'b1010;
`ifdef ONEHOT_ENC_PRIORITY_EN
        exp_code = 2'd3; exp_err = 1'b0; exp_cnt = 8'd1;
`else
        exp_code = 2'd0; exp_err = 1'b1; exp_cnt = 8'd0;
`endif
        tick();
        checks++; if (out_err !== exp_err) begin errors++; $display("FAIL multi_err: got %b exp %b", out_err, exp_err); end
        checks++; if (out_code !== exp_code) begin errors++; $display("FAIL multi_code: got %0d exp %0d", out_code, exp_code); end
        checks++; if (good_cnt !== exp_cnt) begin errors++; $display("FAIL multi_cnt: got %0d exp %0d", good_cnt, exp_cnt); end
        in_onehot = 4'b0110;
`ifdef ONEHOT_ENC_PRIORITY_EN
        exp_code = 2'd2; exp_err = 1'b0; exp_cnt = 8'd2;
`else
        exp_code = 2'd0; exp_err = 1'b1; exp_cnt = 8'd0;
`endif
        tick();
        checks++; if (out_err !== exp_err) begin errors++; $display("FAIL multi2_err: got %b exp %b", out_err, exp_err); end
        checks++; if (out_code !== exp_code) begin errors++; $display("FAIL multi2_code: got %0d exp %0d", out_code, exp_code); end
        checks++; if (good_cnt !== exp_cnt) begin errors++; $display("FAIL multi2_cnt: got %0d exp %0d", good_cnt, exp_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_ignore();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_onehot = 4'b0100;
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid: got %b exp 0", out_valid); end
        checks++; if (good_cnt !== 8'd0) begin errors++; $display("FAIL ignore_cnt: got %0d exp 0", good_cnt); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_onehot = 4'b0001 << (i % 4);
            tick();
            checks++; if (good_cnt2 !== exp_sat[i]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, good_cnt2, exp_sat[i]); end
        end
        checks++; if (good_cnt !== 8'd6) begin errors++; $display("FAIL wide_cnt: got %0d exp 6", good_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_onehot = 4'b0100;
        tick();
        in_valid = 1'b0;
        checks++; if (out_code !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_hold: got valid=%b code=%0d exp valid=1 code=2", out_valid, out_code); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", out_valid); end
        checks++; if (good_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d exp 0", good_cnt); end
        checks++; if (out_code !== 2'd0) begin errors++; $display("FAIL mid_code: got %0d exp 0", out_code); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_ignore();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_encoder_seq.md
ONEHOT_ENCODER_SEQ -- requirements
Module: onehot_encoder_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the good-word counter.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: upstream word present.
REQ-005 SHALL have port in_onehot, input, 4: request word, bit i = line i of a 2-to-4 decode.
REQ-006 SHALL have port in_ready, output, 1: block accepts in_onehot this cycle.
REQ-007 SHALL have port out_valid, output, 1: out_code/out_err hold a result.
REQ-008 SHALL have port out_ready, input, 1: downstream consumes result.
REQ-009 SHALL have port out_code, output, 2: encoded index.
REQ-010 SHALL have port out_err, output, 1: word was not a legal code.
REQ-011 SHALL have port good_cnt, output, CNT_W: count of accepted words with out_err=0.

Function
REQ-012 SHALL map in_onehot 0001->00, 0010->01, 0100->10, 1000->11, the exact inverse of the team's 2-to-4 decoder.
REQ-013 SHALL treat in_onehot=0000 as illegal: out_code=00, out_err=1, in both configurations.
REQ-014 SHALL handle multi-hot words per REQ-029/REQ-030.
REQ-015 SHALL implement a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL drive in_ready = (state==EMPTY) | out_ready, combinationally.
REQ-017 SHALL accept a word when in_valid & in_ready; result appears on out_* on the next cycle (latency 1).
REQ-018 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on out_ready & !accept; FULL->FULL on accept (simultaneous consume and load, result replaced) or on !out_ready.
REQ-019 SHALL hold out_code and out_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL ignore in_onehot when in_valid=0 or in_ready=0; no state change.
REQ-021 SHALL increment good_cnt by 1 on each accept with out_err result 0; illegal words do not count.
REQ-022 SHALL saturate good_cnt at 2^CNT_W-1 (no wrap).
REQ-023 SHALL sustain one word per cycle when out_ready=1 continuously.

Reset
REQ-024 SHALL, while rst_n=0, force state=EMPTY, out_valid=0, out_code=00, out_err=0, good_cnt=0, independent of clk.
REQ-025 SHALL drive in_ready=1 after reset deasserts, as state=EMPTY.
REQ-026 SHALL discard a held result when reset asserts mid-operation; no partial output after release.
REQ-027 SHALL accept a word on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL select behaviour with the macro ONEHOT_ENC_PRIORITY_EN.
REQ-029 SHALL, with ONEHOT_ENC_PRIORITY_EN defined, encode multi-hot words as the highest set index, out_err=0, counted in good_cnt (e.g. 0110->10).
REQ-030 SHALL, without ONEHOT_ENC_PRIORITY_EN, flag multi-hot words out_err=1, out_code=00, not counted.

Verification
REQ-031 SHALL cover: reset, then in_onehot=0001,0010,0100,1000 back-to-back with out_ready=1 -> out_code 00,01,10,11 on cycles 1-4, out_err=0, good_cnt=4.
REQ-032 SHALL cover: in_onehot=1000 accepted, out_ready=0 for 3 cycles, in_valid=1 with 0001 -> out_code=11 held, in_ready=0, good_cnt=1; out_ready=1 -> 0001 accepted same cycle, next out_code=00.
REQ-033 SHALL cover: in_onehot=0000 then 1010 -> out_err=1, out_code=00 both without macro; with macro the second gives out_code=11, out_err=0, good_cnt=1.
REQ-034 SHALL cover: CNT_W=2, six legal words -> good_cnt reads 1,2,3,3,3,3.
REQ-035 SHALL cover: out_valid=1 holding 10, rst_n pulsed low mid-cycle -> out_valid=0, good_cnt=0 immediately, in_ready=1 after release.
